// File: rtl/y86_pkg.sv
// Shared Y86 definitions: icode constants and the PC sequencer state encoding.
package y86_pkg;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    HALT     = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_seq_perf_ctr.sv
// 32-bit saturating event counter with synchronous active-low clear.
// Only built when PC_SEQ_PERF_EN is defined.
`ifdef PC_SEQ_PERF_EN
module pc_seq_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] cnt
);

  // Count one per edge with inc high, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Y86 program-counter sequencer: next-pc selection, ret/halt parking and
// mispredict recovery. Define PC_SEQ_PERF_EN to add mispredict/bubble counters.
module pc_sequencer
  import y86_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        f_icode,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  input  logic              stall,
  input  logic              e_mispredict,
  input  logic [ADDR_W-1:0] e_valA,
  input  logic              w_ret_valid,
  input  logic [ADDR_W-1:0] w_valM,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              d_bubble,
  output logic              halted,
  output logic [1:0]        state
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]       mispredict_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  logic [ADDR_W-1:0] pc_next;
  logic [1:0]        state_next;
  logic              bubble_next;

  // Next-state / next-pc selection; priority mispredict > ret return > stall > prediction.
  always_comb begin
    pc_next    = pc;
    state_next = state;
    if (e_mispredict) begin
      pc_next    = e_valA;
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (!stall) begin
            case (f_icode)
              I_JXX, I_CALL: pc_next = f_valC;
              I_RET: begin
                pc_next    = f_valP;
                state_next = RET_WAIT;
              end
              I_HALT:  state_next = HALT;
              default: pc_next = f_valP;
            endcase
          end
        end
        RET_WAIT: begin
          if (w_ret_valid) begin
            pc_next    = w_valM;
            state_next = RUN;
          end
        end
        HALT:    state_next = HALT;
        default: state_next = RUN;
      endcase
    end
    // Decode gets a bubble after a squash and for every parked cycle.
    bubble_next = e_mispredict || (state_next != RUN);
  end

  // State, pc and bubble registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= RESET_PC;
      state    <= RUN;
      d_bubble <= 1'b0;
    end else begin
      pc       <= pc_next;
      state    <= state_next;
      d_bubble <= bubble_next;
    end
  end

  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALT);

`ifdef PC_SEQ_PERF_EN
  pc_seq_perf_ctr u_mispredict_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (e_mispredict),
    .cnt   (mispredict_cnt)
  );

  pc_seq_perf_ctr u_bubble_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (d_bubble),
    .cnt   (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (RESET_PC=0x100). Counter checks are
// compiled when PC_SEQ_PERF_EN is defined.
module tb_pc_sequencer;

  localparam int unsigned ADDR_W = 64;
  localparam logic [63:0] RPC    = 64'h100;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC, f_valP, e_valA, w_valM;
  logic              stall, e_mispredict, w_ret_valid;
  logic [ADDR_W-1:0] pc;
  logic              fetch_valid, d_bubble, halted;
  logic [1:0]        state;
`ifdef PC_SEQ_PERF_EN
  logic [31:0]       mispredict_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .reset        (reset),
    .f_icode      (f_icode),
    .f_valC       (f_valC),
    .f_valP       (f_valP),
    .stall        (stall),
    .e_mispredict (e_mispredict),
    .e_valA       (e_valA),
    .w_ret_valid  (w_ret_valid),
    .w_valM       (w_valM),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .d_bubble     (d_bubble),
    .halted       (halted),
    .state        (state)
`ifdef PC_SEQ_PERF_EN
    ,
    .mispredict_cnt (mispredict_cnt),
    .bubble_cnt     (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [63:0] epc, input logic [1:0] est,
                           input logic ebub);
    check({tag, "_pc"}, pc, epc);
    check({tag, "_state"}, {62'd0, state}, {62'd0, est});
    check({tag, "_bubble"}, {63'd0, d_bubble}, {63'd0, ebub});
    check({tag, "_fv"}, {63'd0, fetch_valid}, {63'd0, (est == 2'd0)});
    check({tag, "_halted"}, {63'd0, halted}, {63'd0, (est == 2'd2)});
  endtask

  initial begin
    reset = 1'b0; f_icode = 4'h1; f_valC = '0; f_valP = '0; stall = 1'b0;
    e_mispredict = 1'b0; e_valA = '0; w_ret_valid = 1'b0; w_valM = '0;

    // Reset state
    step();
    check_ctl("reset", 64'h100, 2'd0, 1'b0);

    // Release; sequential fetch
    reset = 1'b1; f_icode = 4'h1; f_valP = 64'h101;
    check("release_pc", pc, 64'h100);
    step();
    check_ctl("seq", 64'h101, 2'd0, 1'b0);

    // call then jXX predicted taken
    f_icode = 4'h8; f_valC = 64'h400; f_valP = 64'h10a;
    step();
    check_ctl("call", 64'h400, 2'd0, 1'b0);
    f_icode = 4'h7; f_valC = 64'h200; f_valP = 64'h409;
    step();
    check_ctl("jxx", 64'h200, 2'd0, 1'b0);

    // stall holds pc, keeps fetch_valid, no bubble
    stall = 1'b1; f_icode = 4'h8; f_valC = 64'h999;
    step();
    check_ctl("stall", 64'h200, 2'd0, 1'b0);
    stall = 1'b0;

    // ret: three parked cycles, then return address from writeback
    f_icode = 4'h9; f_valP = 64'h109;
    step();
    check_ctl("ret1", 64'h109, 2'd1, 1'b1);
    f_icode = 4'h1; f_valP = 64'h555;
    step();
    check_ctl("ret2", 64'h109, 2'd1, 1'b1);
    step();
    check_ctl("ret3", 64'h109, 2'd1, 1'b1);
    w_ret_valid = 1'b1; w_valM = 64'h180;
    step();
    check_ctl("ret_done", 64'h180, 2'd0, 1'b0);

    // w_ret_valid outside RET_WAIT ignored
    w_valM = 64'h777; f_icode = 4'h1; f_valP = 64'h181;
    step();
    check_ctl("ret_ignored", 64'h181, 2'd0, 1'b0);
    w_ret_valid = 1'b0;

    // mispredict beats stall and ret completion while in RET_WAIT
    f_icode = 4'h9; f_valP = 64'h18a;
    step();
    check_ctl("ret_enter", 64'h18a, 2'd1, 1'b1);
    e_mispredict = 1'b1; e_valA = 64'h120; stall = 1'b1; w_ret_valid = 1'b1; w_valM = 64'h333;
    step();
    check_ctl("misp_retwait", 64'h120, 2'd0, 1'b1);
    e_mispredict = 1'b0; stall = 1'b0; w_ret_valid = 1'b0; f_icode = 4'h1; f_valP = 64'h122;
    step();
    check_ctl("after_misp", 64'h122, 2'd0, 1'b0);

    // halt parks for 10 cycles
    f_icode = 4'h0; f_valP = 64'h123;
    step();
    check_ctl("halt1", 64'h122, 2'd2, 1'b1);
    f_icode = 4'h8; f_valC = 64'hdead;
    for (int i = 0; i < 9; i++) begin
      step();
      check("halt_hold_pc", pc, 64'h122);
      check("halt_hold_halted", {63'd0, halted}, 64'd1);
    end
    reset = 1'b0;
    step();
    check_ctl("halt_reset", 64'h100, 2'd0, 1'b0);
    reset = 1'b1;

    // mispredict cancels HALT
    f_icode = 4'h0;
    step();
    check_ctl("halt2", 64'h100, 2'd2, 1'b1);
    e_mispredict = 1'b1; e_valA = 64'h140;
    step();
    check_ctl("misp_halt", 64'h140, 2'd0, 1'b1);
    e_mispredict = 1'b0;

    // reset mid-RET_WAIT discards pending ret and mispredict
    f_icode = 4'h9; f_valP = 64'h14a;
    step();
    check_ctl("ret_enter2", 64'h14a, 2'd1, 1'b1);
    reset = 1'b0; w_ret_valid = 1'b1; w_valM = 64'h444; e_mispredict = 1'b1; e_valA = 64'h555;
    step();
    check_ctl("retwait_reset", 64'h100, 2'd0, 1'b0);
    reset = 1'b1; w_ret_valid = 1'b0;

    // two mispredicts plus a 3-cycle RET_WAIT after reset
    e_mispredict = 1'b1; e_valA = 64'h200;
    step();
    check_ctl("pm_misp1", 64'h200, 2'd0, 1'b1);
    e_mispredict = 1'b0; f_icode = 4'h1; f_valP = 64'h201;
    step();
    check_ctl("pm_seq", 64'h201, 2'd0, 1'b0);
    e_mispredict = 1'b1; e_valA = 64'h300;
    step();
    check_ctl("pm_misp2", 64'h300, 2'd0, 1'b1);
    e_mispredict = 1'b0; f_icode = 4'h9; f_valP = 64'h301;
    step();
    step();
    step();
    check_ctl("pm_ret3", 64'h301, 2'd1, 1'b1);
    w_ret_valid = 1'b1; w_valM = 64'h50;
    step();
    check_ctl("pm_ret_done", 64'h50, 2'd0, 1'b0);
    w_ret_valid = 1'b0; f_icode = 4'h1; f_valP = 64'h52;
    step();
    check_ctl("pm_seq2", 64'h52, 2'd0, 1'b0);
`ifdef PC_SEQ_PERF_EN
    check("mispredict_cnt", {32'd0, mispredict_cnt}, 64'd2);
    check("bubble_cnt", {32'd0, bubble_cnt}, 64'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 64, width of all address ports.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; sampled only on rising clk.
REQ-005 f_icode  in  4  icode of instruction fetched at current pc.
REQ-006 f_valC  in  ADDR_W  immediate or destination of fetched instruction.
REQ-007 f_valP  in  ADDR_W  fall-through address of fetched instruction.
REQ-008 stall  in  1  load-use hold from hazard detection.
REQ-009 e_mispredict  in  1  conditional jump in execute resolved not-taken.
REQ-010 e_valA  in  ADDR_W  correct fall-through address for the mispredicted jump.
REQ-011 w_ret_valid  in  1  ret instruction completing in writeback this cycle.
REQ-012 w_valM  in  ADDR_W  return address popped by that ret.
REQ-013 pc  out  ADDR_W  address to fetch this cycle.
REQ-014 fetch_valid  out  1  fetch at pc is architecturally useful.
REQ-015 d_bubble  out  1  insert bubble into decode next cycle.
REQ-016 halted  out  1  sequencer parked after halt.
REQ-017 state  out  2  current FSM state encoding.

Function
REQ-018 FSM states SHALL be RUN=0, RET_WAIT=1, HALT=2; encoding 3 is unreachable and SHALL recover to RUN on the next edge.
REQ-019 In RUN with no higher-priority event, next pc SHALL be f_valC for icode 7 (jXX, predict taken) or 8 (call), f_valP otherwise.
REQ-020 In RUN, icode 9 (ret) SHALL load pc with f_valP and enter RET_WAIT; icode 0 (halt) SHALL hold pc and enter HALT.
REQ-021 In RET_WAIT and HALT, fetch_valid SHALL be 0 and d_bubble SHALL be 1; pc SHALL hold.
REQ-022 In RET_WAIT, w_ret_valid SHALL load pc with w_valM and return to RUN; fetch_valid is 1 the following cycle.
REQ-023 e_mispredict SHALL load pc with e_valA, assert d_bubble for that cycle, and force RUN from any state, cancelling RET_WAIT or HALT.
REQ-024 Priority per edge SHALL be reset > e_mispredict > w_ret_valid (RET_WAIT only) > stall > RUN prediction.
REQ-025 stall SHALL hold pc and state, keep fetch_valid at 1 in RUN, and hold d_bubble at 0.
REQ-026 w_ret_valid outside RET_WAIT SHALL be ignored.
REQ-027 Next-pc arithmetic SHALL be pure selection; no adder, no wrap logic.
REQ-028 halted SHALL equal (state==HALT); all outputs SHALL be registered except halted and fetch_valid, which are decoded from state.

Reset
REQ-029 While reset is low at an edge: pc=RESET_PC, state=RUN, d_bubble=0; fetch_valid=1 and halted=0 follow from RUN.
REQ-030 Reset asserted mid-RET_WAIT or in HALT SHALL discard the pending event; all other inputs SHALL be ignored during reset.

Configuration
REQ-031 With PC_SEQ_PERF_EN defined, 32-bit saturating outputs mispredict_cnt and bubble_cnt SHALL exist, counting e_mispredict edges and d_bubble cycles, cleared by reset.
REQ-032 Without PC_SEQ_PERF_EN, the counter ports and logic SHALL be absent and all other behaviour identical.

Structure
REQ-033 The shared package y86_pkg SHALL hold icode constants (HALT=0, JXX=7, CALL=8, RET=9) and the sequencer state enum.
REQ-034 The counters SHALL be one sub-module, pc_seq_perf_ctr, instantiated twice and compiled only under PC_SEQ_PERF_EN.

Verification
REQ-035 Reset with RESET_PC=0x100, then release; f_icode=1, f_valP=0x101 -> pc=0x100 then 0x101, fetch_valid=1.
REQ-036 f_icode=8, f_valC=0x400 -> next pc=0x400; f_icode=7, f_valC=0x200 -> next pc=0x200.
REQ-037 f_icode=9, f_valP=0x109 -> state=RET_WAIT, d_bubble=1 for 3 cycles; w_ret_valid=1, w_valM=0x180 -> pc=0x180, state=RUN.
REQ-038 e_mispredict=1, e_valA=0x120 coincident with stall=1 and RET_WAIT -> pc=0x120, state=RUN, d_bubble=1.
REQ-039 f_icode=0 -> halted=1 and pc held for 10 cycles; then reset low for 1 edge -> pc=RESET_PC, halted=0.
REQ-040 With PC_SEQ_PERF_EN defined, 2 mispredicts plus one 3-cycle RET_WAIT -> mispredict_cnt=2, bubble_cnt=5.
